wf68k30l_multiplier: RTL and testbench
======================================

Name: wf68k30l_multiplier

Overview:
- Sequential shift-add multiplier serving MULS/MULU, the companion to the ALU's division state machine.
- Supported sizes: 16x16->32, 32x32->32 and 32x32->64 (selected by BIW_1[10]).
- Started by the ALU with ALU_INIT. Returns product high/low words, overflow flag and a one-cycle ready strobe.
- Radix-2, one multiplier bit per clock. Operands are made positive first and the sign is corrected at the end.

Parameters:
- None. Opcode constants MULS/MULU and size constants WORD/LONG come from the core package.

Ports:
- CLK  in  1  core clock, rising edge
- RESETn  in  1  reset, asynchronous, active-low
- ALU_INIT  in  1  start qualifier
- OP_IN  in  7  decoded opcode, sampled with ALU_INIT
- OP  in  7  opcode, latched in INIT
- OP_SIZE  in  2  WORD or LONG, latched in INIT
- BIW_1  in  16  extension word; bit 10 = 64-bit product, latched in INIT
- OP1  in  32  source operand (multiplicand), latched in INIT
- OP2  in  32  destination operand (multiplier), latched in INIT
- RESULT_LO  out  32  product bits 31:0
- RESULT_HI  out  32  product bits 63:32
- VFLAG_MUL  out  1  overflow
- MUL_RDY  out  1  one-cycle completion strobe
- MUL_BUSY  out  1  high in INIT and CALC

Behaviour:
- Reset (async, RESETn low):
  - State goes to MUL_IDLE.
  - RESULT_LO, RESULT_HI, VFLAG_MUL, MUL_RDY and MUL_BUSY all go to 0.
  - An operation in progress is aborted with no MUL_RDY.
- MUL_IDLE: on ALU_INIT=1 with OP_IN==MULS or MULU, move to MUL_INIT. All other opcodes are ignored.
- MUL_INIT (one cycle):
  - Latch OP, OP_SIZE, BIW_1[10], OP1, OP2. Inputs may change freely afterwards.
  - WORD operands: OP1[15:0] and OP2[15:0], sign-extended for MULS, zero-extended for MULU. LONG operands: full 32 bits.
  - MULS: store the absolute value of each operand (two's-complement negate if negative). Result sign = XOR of the operand signs.
  - Clear the 64-bit accumulator.
  - Set BITCNT to 16 for WORD, 32 for LONG.
  - If either absolute operand is 0: outputs become 0, VFLAG_MUL=0, MUL_RDY=1 on the next edge, return to MUL_IDLE.
  - Otherwise move to MUL_CALC.
- MUL_CALC (BITCNT cycles), each cycle:
  - If multiplier LSB=1: acc_hi(33-bit) += multiplicand.
  - Shift {carry, acc_hi, multiplier} right by 1.
  - BITCNT -= 1.
- Final CALC cycle (BITCNT reaches 0), on that same edge:
  - If the result sign is set, negate the 64-bit magnitude.
  - Load RESULT_HI/LO, set VFLAG_MUL, pulse MUL_RDY=1, go to MUL_IDLE.
- Latency from the ALU_INIT edge to MUL_RDY high:
  - WORD: 18 cycles.
  - LONG: 34 cycles.
  - Zero shortcut: 2 cycles.
- RESULT_HI always holds bits 63:32 of the full signed (MULS) or unsigned (MULU) product. For WORD this is the sign/zero extension.
- VFLAG_MUL:
  - WORD: 0.
  - LONG 64-bit (BIW_1[10]=1): 0.
  - LONG 32-bit, MULU: 1 when the product's high 32 bits are non-zero.
  - LONG 32-bit, MULS: 1 when the 64-bit product is not the sign extension of bit 31.
  - When VFLAG_MUL=1, RESULT_LO still holds the low 32 bits.
- Outputs hold their values until the next MUL_INIT. MUL_INIT itself leaves them unchanged except on the zero shortcut.
- MUL_RDY is exactly one cycle wide, and is 0 in every other state.
- ALU_INIT while MUL_BUSY=1 is ignored. There is no restart.
- MULS.L 0x80000000 x 0x80000000: the magnitude 2^31 must not overflow the 33-bit acc_hi. The required result is 0x40000000_00000000.

Test Plan:
- MULU.W, OP1=0x0000FFFF, OP2=0x1234FFFF -> 18 cycles later MUL_RDY=1 for one cycle; RESULT_LO=0xFFFE0001, RESULT_HI=0, V=0.
- MULS.W, OP1=0xFFFE (-2), OP2=0x0003 -> RESULT_LO=0xFFFFFFFA, RESULT_HI=0xFFFFFFFF, V=0.
- MULU.L 32-bit, OP1=OP2=0x00010000 -> RESULT_LO=0, RESULT_HI=1, V=1, MUL_RDY at 34 cycles.
- MULS.L 64-bit, OP1=OP2=0x80000000 -> HI=0x40000000, LO=0, V=0.
- MULS.L 32-bit, OP1=OP2=0xFFFFFFFF -> LO=1, HI=0, V=0.
- OP1=0 (any size) -> MUL_RDY 2 cycles after ALU_INIT, results 0.
- RESETn low at cycle 10 of a LONG operation -> outputs 0, no MUL_RDY; a re-issued operation then completes correctly.

Source files
------------

// File: rtl/wf68k30l_multiplier.sv
`default_nettype none
// ============================================================================
// wf68k30l_multiplier : radix-2 shift-add multiplier for MULS/MULU (W, L, L64)
// Revision : 1.0
// ============================================================================
module wf68k30l_multiplier (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        ALU_INIT,
  input  logic [6:0]  OP_IN,
  input  logic [6:0]  OP,
  input  logic [1:0]  OP_SIZE,
  input  logic [15:0] BIW_1,
  input  logic [31:0] OP1,
  input  logic [31:0] OP2,
  output logic [31:0] RESULT_LO,
  output logic [31:0] RESULT_HI,
  output logic        VFLAG_MUL,
  output logic        MUL_RDY,
  output logic        MUL_BUSY
);

  localparam logic [6:0] C_MULS = 7'd40;
  localparam logic [6:0] C_MULU = 7'd41;
  localparam logic [1:0] C_LONG = 2'd0;
  localparam logic [1:0] C_WORD = 2'd1;

  typedef enum logic [1:0] {MUL_IDLE = 2'd0, MUL_INIT = 2'd1, MUL_CALC = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        signed_q, signed_d;
  logic        word_q, word_d;
  logic        long64_q, long64_d;
  logic        sign_q, sign_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic        vflag_q, vflag_d;
  logic        rdy_q, rdy_d;

  logic        w_op_s, w_size_w, w_a_neg, w_b_neg;
  logic [31:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs;
  logic [32:0] w_sum;
  logic [31:0] w_acc_nxt, w_mpl_nxt;
  logic [63:0] w_mag, w_prod;
  logic        w_unused;

  assign w_unused = ^{BIW_1[15:11], BIW_1[9:0]};

  // Operand conditioning from the live inputs, consumed in MUL_INIT.
  assign w_op_s   = (OP == C_MULS);
  assign w_size_w = (OP_SIZE == C_WORD);
  assign w_a_ext  = w_size_w ? {{16{w_op_s & OP1[15]}}, OP1[15:0]} : OP1;
  assign w_b_ext  = w_size_w ? {{16{w_op_s & OP2[15]}}, OP2[15:0]} : OP2;
  assign w_a_neg  = w_op_s & w_a_ext[31];
  assign w_b_neg  = w_op_s & w_b_ext[31];
  assign w_a_abs  = w_a_neg ? (~w_a_ext + 32'd1) : w_a_ext;
  assign w_b_abs  = w_b_neg ? (~w_b_ext + 32'd1) : w_b_ext;

  // One shift-add step; the 33rd sum bit is the carry shifted into acc_hi.
  assign w_sum     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign w_acc_nxt = w_sum[32:1];
  assign w_mpl_nxt = {w_sum[0], mplier_q[31:1]};
  // After 16 steps a word product sits 16 bits above its natural position.
  assign w_mag     = word_q ? {16'd0, w_acc_nxt, w_mpl_nxt[31:16]} : {w_acc_nxt, w_mpl_nxt};
  assign w_prod    = sign_q ? (~w_mag + 64'd1) : w_mag;

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    word_d   = word_q;
    long64_d = long64_q;
    sign_d   = sign_q;
    bitcnt_d = bitcnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    vflag_d  = vflag_q;
    rdy_d    = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (ALU_INIT && (OP_IN == C_MULS || OP_IN == C_MULU)) state_d = MUL_INIT;
      end
      MUL_INIT: begin
        signed_d = w_op_s;
        word_d   = w_size_w;
        long64_d = BIW_1[10];
        sign_d   = w_a_neg ^ w_b_neg;
        mcand_d  = w_a_abs;
        mplier_d = w_b_abs;
        acc_d    = 32'd0;
        bitcnt_d = w_size_w ? 6'd16 : 6'd32;
        if (w_a_abs == 32'd0 || w_b_abs == 32'd0) begin
          res_lo_d = 32'd0;
          res_hi_d = 32'd0;
          vflag_d  = 1'b0;
          rdy_d    = 1'b1;
          state_d  = MUL_IDLE;
        end else begin
          state_d  = MUL_CALC;
        end
      end
      MUL_CALC: begin
        acc_d    = w_acc_nxt;
        mplier_d = w_mpl_nxt;
        bitcnt_d = bitcnt_q - 6'd1;
        if (bitcnt_q == 6'd1) begin
          res_lo_d = w_prod[31:0];
          res_hi_d = w_prod[63:32];
          if (word_q || long64_q)
            vflag_d = 1'b0;
          else if (signed_q)
            vflag_d = (w_prod[63:32] != {32{w_prod[31]}});
          else
            vflag_d = (w_prod[63:32] != 32'd0);
          rdy_d    = 1'b1;
          state_d  = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= MUL_IDLE;
      signed_q <= 1'b0;
      word_q   <= 1'b0;
      long64_q <= 1'b0;
      sign_q   <= 1'b0;
      bitcnt_q <= 6'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
      vflag_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      word_q   <= word_d;
      long64_q <= long64_d;
      sign_q   <= sign_d;
      bitcnt_q <= bitcnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      vflag_q  <= vflag_d;
      rdy_q    <= rdy_d;
    end
  end

  assign RESULT_LO = res_lo_q;
  assign RESULT_HI = res_hi_q;
  assign VFLAG_MUL = vflag_q;
  assign MUL_RDY   = rdy_q;
  assign MUL_BUSY  = (state_q != MUL_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wf68k30l_multiplier.sv
`default_nettype none
// ============================================================================
// tb_wf68k30l_multiplier : directed checks of products, flags and latency
// Revision : 1.0
// ============================================================================
module tb_wf68k30l_multiplier;

  localparam logic [6:0] C_MULS = 7'd40;
  localparam logic [6:0] C_MULU = 7'd41;
  localparam logic [1:0] C_LONG = 2'd0;
  localparam logic [1:0] C_WORD = 2'd1;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        ALU_INIT;
  logic [6:0]  OP_IN, OP;
  logic [1:0]  OP_SIZE;
  logic [15:0] BIW_1;
  logic [31:0] OP1, OP2;
  logic [31:0] RESULT_LO, RESULT_HI;
  logic        VFLAG_MUL, MUL_RDY, MUL_BUSY;

  int checks = 0;
  int errors = 0;

  wf68k30l_multiplier dut (
    .CLK(CLK), .RESETn(RESETn), .ALU_INIT(ALU_INIT), .OP_IN(OP_IN), .OP(OP),
    .OP_SIZE(OP_SIZE), .BIW_1(BIW_1), .OP1(OP1), .OP2(OP2),
    .RESULT_LO(RESULT_LO), .RESULT_HI(RESULT_HI), .VFLAG_MUL(VFLAG_MUL),
    .MUL_RDY(MUL_RDY), .MUL_BUSY(MUL_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble inputs after INIT, and check the result.
  task automatic run_op(input string tag, input logic [6:0] op, input logic [1:0] sz,
                        input logic b10, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input logic ev, input int elat);
    int cnt;
    bit seen;
    @(posedge CLK); #1;
    ALU_INIT = 1'b1; OP_IN = op; OP = op; OP_SIZE = sz;
    BIW_1 = b10 ? 16'h0400 : 16'h0000; OP1 = a; OP2 = b;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 100) begin
      @(posedge CLK); #1;
      cnt++;
      if (cnt == 1) begin
        ALU_INIT = 1'b0;
        chk({tag, "_busy"}, MUL_BUSY, 1'b1);
      end
      if (MUL_RDY) seen = 1'b1;
      if (cnt == 2) begin
        OP1 = ~a; OP2 = 32'h5A5A_1234; OP_SIZE = ~sz; BIW_1 = ~BIW_1; OP = 7'd0;
      end
      if (cnt == 5) begin ALU_INIT = 1'b1; OP_IN = C_MULU; end
      if (cnt == 6) ALU_INIT = 1'b0;
    end
    ALU_INIT = 1'b0;
    chk({tag, "_rdy"}, seen, 1'b1);
    chk({tag, "_lat"}, cnt, elat);
    chk({tag, "_lo"}, RESULT_LO, elo);
    chk({tag, "_hi"}, RESULT_HI, ehi);
    chk({tag, "_v"}, VFLAG_MUL, ev);
    @(posedge CLK); #1;
    chk({tag, "_rdy_width"}, MUL_RDY, 1'b0);
    chk({tag, "_hold"}, RESULT_LO, elo);
  endtask

  initial begin
    int rdy_seen;
    RESETn = 1'b0; ALU_INIT = 1'b0; OP_IN = 7'd0; OP = 7'd0; OP_SIZE = C_LONG;
    BIW_1 = 16'h0; OP1 = 32'h0; OP2 = 32'h0;
    #1;
    chk("reset_lo", RESULT_LO, 32'h0);
    chk("reset_hi", RESULT_HI, 32'h0);
    chk("reset_flags", {VFLAG_MUL, MUL_RDY, MUL_BUSY}, 3'b000);
    #20 RESETn = 1'b1;

    run_op("muluw",   C_MULU, C_WORD, 1'b0, 32'h0000FFFF, 32'h1234FFFF, 32'hFFFE0001, 32'h0, 1'b0, 18);
    run_op("mulsw",   C_MULS, C_WORD, 1'b0, 32'h0000FFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 18);
    run_op("mulul32", C_MULU, C_LONG, 1'b0, 32'h00010000, 32'h00010000, 32'h0, 32'h1, 1'b1, 34);
    run_op("mulsl64", C_MULS, C_LONG, 1'b1, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 1'b0, 34);
    run_op("mulsl32", C_MULS, C_LONG, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 34);
    run_op("mulsl32v", C_MULS, C_LONG, 1'b0, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h0, 1'b1, 34);
    run_op("mulsl64n", C_MULS, C_LONG, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 34);

    // Reset ten cycles into a long operation.
    @(posedge CLK); #1;
    ALU_INIT = 1'b1; OP_IN = C_MULU; OP = C_MULU; OP_SIZE = C_LONG; BIW_1 = 16'h0;
    OP1 = 32'h00010000; OP2 = 32'h00010000;
    @(posedge CLK); #1 ALU_INIT = 1'b0;
    repeat (9) @(posedge CLK);
    #2 RESETn = 1'b0;
    #1;
    chk("abort_lo", RESULT_LO, 32'h0);
    chk("abort_hi", RESULT_HI, 32'h0);
    chk("abort_flags", {VFLAG_MUL, MUL_RDY, MUL_BUSY}, 3'b000);
    @(posedge CLK); #3 RESETn = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (MUL_RDY) rdy_seen++;
    end
    chk("abort_no_rdy", rdy_seen, 0);
    run_op("reissue", C_MULU, C_LONG, 1'b0, 32'h00010000, 32'h00010000, 32'h0, 32'h1, 1'b1, 34);

    run_op("zero_l", C_MULS, C_LONG, 1'b0, 32'h0, 32'h12345678, 32'h0, 32'h0, 1'b0, 2);
    run_op("mulsw2", C_MULS, C_WORD, 1'b0, 32'hABCD8000, 32'h00007FFF, 32'hC0008000, 32'hFFFFFFFF, 1'b0, 18);
    run_op("zero_w", C_MULU, C_WORD, 1'b0, 32'h12340000, 32'h0000FFFF, 32'h0, 32'h0, 1'b0, 2);

    // A non-multiply opcode must not start anything.
    @(posedge CLK); #1;
    ALU_INIT = 1'b1; OP_IN = 7'd5; OP = 7'd5; OP1 = 32'h3; OP2 = 32'h3;
    @(posedge CLK); #1 ALU_INIT = 1'b0;
    chk("ignore_busy", MUL_BUSY, 1'b0);
    rdy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (MUL_RDY) rdy_seen++;
    end
    chk("ignore_no_rdy", rdy_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
